mpu_matrix_loader: RTL and testbench

MPU_MATRIX_LOADER -- requirements
Module: mpu_matrix_loader

---
 rtl/mpu_matrix_loader.sv | 120 ++++++++++++
 tb/tb_mpu_matrix_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_matrix_loader.sv
// Streams two 5x5 signed 8-bit operand matrices row-major into flattened buses
// and latches the command fields that go with them for the operation stage.
module mpu_matrix_loader (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [2:0]          operation_in,
    input  logic [7:0]          size_in,
    input  logic signed [7:0]   factor_in,
    input  logic                in_valid,
    input  logic signed [7:0]   in_data,
    output logic                in_ready,
    output logic signed [199:0] matrix_a,
    output logic signed [199:0] matrix_b,
    output logic [2:0]          operation,
    output logic [7:0]          size,
    output logic signed [7:0]   factor,
    output logic                busy,
    output logic                done,
    output logic                error
);
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] row;
    logic [2:0] col;
    logic [7:0] wr_base;
    logic       xfer;
    logic       last_col;
    logic       last_elem;
    logic       accept;
    logic       reject;

    function automatic logic size_legal(input logic [7:0] s);
        return (s >= 8'd2) && (s <= 8'd5);
    endfunction

    // Operations that consume a second operand matrix.
    function automatic logic needs_b(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd6);
    endfunction

    function automatic logic [4:0] elem_index(input logic [2:0] r, input logic [2:0] c);
        return ({2'b00, r} * 5'd5) + {2'b00, c};
    endfunction

    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign xfer      = in_valid && in_ready;
    assign accept    = (state == IDLE) && start && size_legal(size_in);
    assign reject    = (state == IDLE) && start && !size_legal(size_in);
    assign last_col  = ({5'd0, col} == (size - 8'd1));
    assign last_elem = last_col && ({5'd0, row} == (size - 8'd1));
    assign wr_base   = {elem_index(row, col), 3'b000};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD_A;
            LOAD_A:  if (xfer && last_elem) state_nxt = needs_b(operation) ? LOAD_B : DONE;
            LOAD_B:  if (xfer && last_elem) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            error <= reject;
        end
    end

    // Command latch, counters and element write; untouched elements stay zero.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            row       <= 3'd0;
            col       <= 3'd0;
            matrix_a  <= '0;
            matrix_b  <= '0;
            operation <= 3'd0;
            size      <= 8'd0;
            factor    <= 8'sd0;
        end else if (accept) begin
            row       <= 3'd0;
            col       <= 3'd0;
            matrix_a  <= '0;
            matrix_b  <= '0;
            operation <= operation_in;
            size      <= size_in;
            factor    <= factor_in;
        end else if (xfer) begin
            if (last_elem) begin
                row <= 3'd0;
                col <= 3'd0;
            end else if (last_col) begin
                row <= row + 3'd1;
                col <= 3'd0;
            end else begin
                col <= col + 3'd1;
            end
            if (state == LOAD_A)
                matrix_a[wr_base +: DATA_W] <= in_data;
            else
                matrix_b[wr_base +: DATA_W] <= in_data;
        end
    end
endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Bench for mpu_matrix_loader: table-driven loads checked through a done-driven
// scoreboard, plus hand sequences for illegal size, busy start and mid-load reset.
module tb_mpu_matrix_loader;
    logic                clock = 1'b0;
    logic                reset_n;
    logic                start;
    logic [2:0]          operation_in;
    logic [7:0]          size_in;
    logic signed [7:0]   factor_in;
    logic                in_valid;
    logic signed [7:0]   in_data;
    logic                in_ready;
    logic signed [199:0] matrix_a;
    logic signed [199:0] matrix_b;
    logic [2:0]          operation;
    logic [7:0]          size;
    logic signed [7:0]   factor;
    logic                busy;
    logic                done;
    logic                error;

    mpu_matrix_loader dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .operation_in(operation_in), .size_in(size_in), .factor_in(factor_in),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .matrix_a(matrix_a), .matrix_b(matrix_b), .operation(operation),
        .size(size), .factor(factor), .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [199:0] a;
        logic [199:0] b;
        logic [2:0]   op;
        logic [7:0]   sz;
        logic [7:0]   fac;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] sz;
        logic [7:0] fac;
        int         first;
        int         step;
        bit         gaps;
        int         exp_xfers;
    } vec_t;

    exp_t sb[$];
    exp_t last_exp;
    exp_t mon_e;
    vec_t vecs[5];
    int   errors = 0;
    int   checks = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk200(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: each done pulse retires the oldest pending load.
    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=1 want no pending load");
            end else begin
                mon_e = sb.pop_front();
                chk200("sb_matrix_a", matrix_a, mon_e.a);
                chk200("sb_matrix_b", matrix_b, mon_e.b);
                chk8("sb_operation", {5'd0, operation}, {5'd0, mon_e.op});
                chk8("sb_size", size, mon_e.sz);
                chk8("sb_factor", factor, mon_e.fac);
            end
        end
    end

    function automatic logic [7:0] elem_val(input int first, input int step, input int j);
        return 8'(first + j * step);
    endfunction

    // Drives one load; inject>=0 pulses a stray start at that transfer index,
    // abort>=0 stops streaming after that many transfers (caller resets).
    task automatic run_load(input logic [2:0] op, input logic [7:0] sz, input logic [7:0] fac,
                            input int first, input int step, input bit gaps,
                            input int inject, input int abort, output int xfers);
        exp_t e;
        int   n, total, guard, jj, k;
        logic acc;
        n     = int'(sz) * int'(sz);
        total = (op == 3'd0 || op == 3'd1 || op == 3'd6) ? 2 * n : n;
        e.a = '0; e.b = '0; e.op = op; e.sz = sz; e.fac = fac;
        for (int j = 0; j < total; j++) begin
            jj = j % n;
            k  = 5 * (jj / int'(sz)) + (jj % int'(sz));
            if (j < n) e.a[8*k +: 8] = elem_val(first, step, j);
            else       e.b[8*k +: 8] = elem_val(first, step, j);
        end
        sb.push_back(e);

        operation_in = op; size_in = sz; factor_in = fac; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        chk1("start_busy", busy, 1'b1);
        chk1("start_in_ready", in_ready, 1'b1);
        chk200("start_clear_a", matrix_a, 200'd0);
        chk200("start_clear_b", matrix_b, 200'd0);
        @(posedge clock); #1;

        xfers = 0;
        guard = 0;
        while (xfers < total && xfers != abort && guard < 2000) begin
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = elem_val(first, step, xfers);
            end
            if (xfers == inject) begin
                start = 1'b1; operation_in = 3'd3; size_in = 8'd4; factor_in = 8'sd7;
            end
            @(negedge clock);
            acc = in_valid && in_ready;
            @(posedge clock); #1;
            start = 1'b0;
            if (acc) xfers++;
        end
        in_valid = 1'b0;
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got %0d transfers want %0d", xfers, total);
        end
        if (xfers == abort) return;

        @(negedge clock);
        chk1("done_latency", done, 1'b1);
        chk1("done_in_ready", in_ready, 1'b0);
        @(posedge clock); #1;
        last_exp = e;
    endtask

    task automatic illegal_start(input logic [7:0] sz);
        start = 1'b1; size_in = sz; operation_in = 3'd5; factor_in = 8'sd9;
        in_valid = 1'b1; in_data = 8'sd55;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        chk1("illegal_error", error, 1'b1);
        chk1("illegal_in_ready", in_ready, 1'b0);
        chk1("illegal_busy", busy, 1'b0);
        chk200("illegal_hold_a", matrix_a, last_exp.a);
        chk200("illegal_hold_b", matrix_b, last_exp.b);
        chk8("illegal_hold_size", size, last_exp.sz);
        chk8("illegal_hold_factor", factor, last_exp.fac);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk1("illegal_error_pulse", error, 1'b0);
        @(posedge clock); #1;
    endtask

    initial begin
        int x;
        vecs[0] = '{op: 3'd0, sz: 8'd3, fac: 8'h02, first: 1,    step: 1,  gaps: 1'b0, exp_xfers: 18};
        vecs[1] = '{op: 3'd4, sz: 8'd5, fac: 8'h00, first: -1,   step: -1, gaps: 1'b1, exp_xfers: 25};
        vecs[2] = '{op: 3'd1, sz: 8'd2, fac: 8'hFB, first: 100,  step: 3,  gaps: 1'b1, exp_xfers: 8};
        vecs[3] = '{op: 3'd6, sz: 8'd4, fac: 8'h7F, first: -128, step: 7,  gaps: 1'b0, exp_xfers: 32};
        vecs[4] = '{op: 3'd7, sz: 8'd2, fac: 8'hFF, first: 5,    step: 1,  gaps: 1'b0, exp_xfers: 4};

        reset_n = 1'b0; start = 1'b0; operation_in = 3'd0; size_in = 8'd0;
        factor_in = 8'sd0; in_valid = 1'b0; in_data = 8'sd0;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk200("rst_matrix_a", matrix_a, 200'd0);
        chk200("rst_matrix_b", matrix_b, 200'd0);
        chk8("rst_operation", {5'd0, operation}, 8'd0);
        chk8("rst_size", size, 8'd0);
        chk8("rst_factor", factor, 8'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 5; i++) begin
            run_load(vecs[i].op, vecs[i].sz, vecs[i].fac, vecs[i].first, vecs[i].step,
                     vecs[i].gaps, -1, -1, x);
            chki("xfer_count", x, vecs[i].exp_xfers);
            if (i == 0) begin
                chk8("add_a00", matrix_a[7:0], 8'd1);
                chk8("add_a22", matrix_a[103:96], 8'd9);
                chk8("add_a03", matrix_a[31:24], 8'd0);
                chk8("add_b00", matrix_b[7:0], 8'd10);
                chk8("add_b22", matrix_b[103:96], 8'd18);
                @(negedge clock);
                chk1("done_one_cycle", done, 1'b0);
                chk1("idle_after_done", busy, 1'b0);
                @(posedge clock); #1;
            end
            if (i == 1) begin
                chk8("tr_a_first", matrix_a[7:0], 8'hFF);
                chk8("tr_a_last", matrix_a[199:192], 8'hE7);
                chk200("tr_b_zero", matrix_b, 200'd0);
            end
        end

        illegal_start(8'd6);
        illegal_start(8'd1);
        illegal_start(8'd0);

        run_load(3'd2, 8'd2, 8'hFD, 4, 1, 1'b0, 1, -1, x);
        chki("busy_start_xfers", x, 4);
        chk8("busy_start_operation", {5'd0, operation}, 8'd2);
        chk8("busy_start_factor", factor, 8'hFD);
        chk8("busy_start_size", size, 8'd2);

        run_load(3'd1, 8'd2, 8'h0A, 1, 1, 1'b0, -1, 5, x);
        chki("abort_xfers", x, 5);
        reset_n = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk200("mid_rst_a", matrix_a, 200'd0);
        chk200("mid_rst_b", matrix_b, 200'd0);
        chk8("mid_rst_size", size, 8'd0);
        chk8("mid_rst_factor", factor, 8'd0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_in_ready", in_ready, 1'b0);
        reset_n = 1'b1;
        sb.delete();
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk1("mid_rst_no_done", done, 1'b0);
        end
        @(posedge clock); #1;
        run_load(3'd1, 8'd2, 8'h0A, 1, 1, 1'b0, -1, -1, x);
        chki("fresh_xfers", x, 8);

        repeat (2) @(posedge clock);
        chki("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
